// File: rtl/dds_tuning_if.sv
// Bus between the frequency comparator/host and the DDS tuning controller:
// loop controls and comparator verdict in, tuning word and NCO status out.
interface dds_tuning_if #(
  parameter int ACC_W = 24
);
  logic             Enable;
  logic             Slow;
  logic             Fast;
  logic [7:0]       Time_Frame;
  logic [ACC_W-1:0] FTW;
  logic             DDS_Out;
  logic             Locked;
  logic [1:0]       State;

  // master drives the comparator side, slave is the controller
  modport master (
    output Enable, Slow, Fast, Time_Frame,
    input  FTW, DDS_Out, Locked, State
  );

  modport slave (
    input  Enable, Slow, Fast, Time_Frame,
    output FTW, DDS_Out, Locked, State
  );
endinterface

// File: rtl/dds_tuning_ctrl.sv
// PLL loop controller + NCO. Once per comparator frame the Slow/Fast verdict
// steps the frequency tuning word through a COARSE -> FINE -> LOCK search;
// a phase accumulator driven by the FTW produces DDS_Out.
module dds_tuning_ctrl #(
  parameter int               ACC_W        = 24,
  parameter logic [ACC_W-1:0] INIT_FTW     = 24'h100000,
  parameter logic [ACC_W-1:0] FTW_MIN      = 24'h000100,
  parameter logic [ACC_W-1:0] FTW_MAX      = 24'h7FFFFF,
  parameter logic [ACC_W-1:0] COARSE_STEP  = 24'h001000,
  parameter logic [ACC_W-1:0] FINE_STEP    = 24'h000040,
  parameter logic [7:0]       SAMPLE_FRAME = 8'd31,
  parameter int               LOCK_COUNT   = 4
) (
  input  logic         REF_Clk,
  input  logic         Reset,
  dds_tuning_if.slave  bus
);

  localparam int BAL_W = $clog2(LOCK_COUNT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COARSE = 2'd1;
  localparam logic [1:0] ST_FINE   = 2'd2;
  localparam logic [1:0] ST_LOCK   = 2'd3;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DN   = 2'd2;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             dds_q, dds_d;
  logic [ACC_W-1:0] ftw_q, ftw_d;
  logic             locked_q, locked_d;
  logic [1:0]       state_q, state_d;
  logic [BAL_W-1:0] bal_cnt_q, bal_cnt_d;
  logic             miss_cnt_q, miss_cnt_d;
  logic [1:0]       last_dir_q, last_dir_d;
  logic             eq_q, eq_d;

  logic dec_stb, is_up, is_dn, is_step, reversal;

  // Step in ACC_W+1 bits so neither direction can wrap, then saturate.
  function automatic logic [ACC_W-1:0] apply_step(input logic [ACC_W-1:0] ftw,
                                                  input logic [ACC_W-1:0] step,
                                                  input logic             up);
    logic [ACC_W:0] r;
    if (up) r = {1'b0, ftw} + {1'b0, step};
    else    r = {1'b0, ftw} - {1'b0, step};
    if (!up && r[ACC_W])         return FTW_MIN;
    if (r > {1'b0, FTW_MAX})     return FTW_MAX;
    if (r < {1'b0, FTW_MIN})     return FTW_MIN;
    return r[ACC_W-1:0];
  endfunction

  // Strobe on the first cycle of SAMPLE_FRAME only; a stalled counter gives one pulse.
  always_comb begin
    eq_d    = (bus.Time_Frame == SAMPLE_FRAME);
    dec_stb = eq_d & ~eq_q;
    is_up   = bus.Slow & ~bus.Fast;
    is_dn   = bus.Fast & ~bus.Slow;
    is_step = is_up | is_dn;
    reversal = ((last_dir_q == DIR_UP) && is_dn) || ((last_dir_q == DIR_DN) && is_up);
  end

  // NCO: free-running accumulator, wraps silently, runs in every state.
  always_comb begin
    acc_d = acc_q + ftw_q;
    dds_d = acc_d[ACC_W-1];
  end

  // Loop FSM; Enable low wins over any strobe in the same cycle.
  always_comb begin
    state_d    = state_q;
    ftw_d      = ftw_q;
    locked_d   = locked_q;
    bal_cnt_d  = bal_cnt_q;
    miss_cnt_d = miss_cnt_q;
    last_dir_d = last_dir_q;
    if (!bus.Enable) begin
      state_d    = ST_IDLE;
      ftw_d      = INIT_FTW;
      locked_d   = 1'b0;
      bal_cnt_d  = '0;
      miss_cnt_d = 1'b0;
      last_dir_d = DIR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_COARSE;
          last_dir_d = DIR_NONE;
        end
        ST_COARSE: begin
          if (dec_stb) begin
            if (is_step) begin
              // a reversal means we bracketed the target: finish the frame with a fine step
              ftw_d      = apply_step(ftw_q, reversal ? FINE_STEP : COARSE_STEP, is_up);
              last_dir_d = is_up ? DIR_UP : DIR_DN;
              if (reversal) state_d = ST_FINE;
            end else begin
              state_d = ST_FINE;
            end
          end
        end
        ST_FINE: begin
          if (dec_stb) begin
            if (is_step) begin
              ftw_d     = apply_step(ftw_q, FINE_STEP, is_up);
              bal_cnt_d = '0;
            end else if (bal_cnt_q == BAL_W'(LOCK_COUNT - 1)) begin
              state_d    = ST_LOCK;
              locked_d   = 1'b1;
              bal_cnt_d  = '0;
              miss_cnt_d = 1'b0;
            end else begin
              bal_cnt_d = bal_cnt_q + 1'b1;
            end
          end
        end
        default: begin // ST_LOCK
          if (dec_stb) begin
            if (is_step) begin
              ftw_d = apply_step(ftw_q, FINE_STEP, is_up);
              // one miss is tolerated; two in a row drop back to FINE
              if (miss_cnt_q) begin
                state_d    = ST_FINE;
                locked_d   = 1'b0;
                miss_cnt_d = 1'b0;
              end else begin
                miss_cnt_d = 1'b1;
              end
            end else begin
              miss_cnt_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge REF_Clk or posedge Reset) begin
    if (Reset) begin
      acc_q      <= '0;
      dds_q      <= 1'b0;
      ftw_q      <= INIT_FTW;
      locked_q   <= 1'b0;
      state_q    <= ST_IDLE;
      bal_cnt_q  <= '0;
      miss_cnt_q <= 1'b0;
      last_dir_q <= DIR_NONE;
      eq_q       <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      dds_q      <= dds_d;
      ftw_q      <= ftw_d;
      locked_q   <= locked_d;
      state_q    <= state_d;
      bal_cnt_q  <= bal_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      last_dir_q <= last_dir_d;
      eq_q       <= eq_d;
    end
  end

  assign bus.FTW     = ftw_q;
  assign bus.DDS_Out = dds_q;
  assign bus.Locked  = locked_q;
  assign bus.State   = state_q;

endmodule
